rr_arbiter_4: RTL and testbench

Four-requester round-robin arbiter that shares one resource among requesters 0-3 and drives it through a 2-bit select plus one-hot enable, the same select/one-hot form as the team's 2-to-4 decoder. A requester holds the grant until it signals done, drops its request, or hits a hold-time limit. Rotating priority prevents starvation. The block sits between the requesting units and the shared decoder-addressed resource.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_arbiter_4_if.sv | 21 ++
 rtl/onehot_dec4.sv | 13 +
 rtl/rr_arbiter_4.sv | 107 ++++++++++
 tb/tb_rr_arbiter_4.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and pointer helper for the round-robin arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [1:0] inc_mod4(input logic [1:0] v);
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesting units and the arbiter.
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic               gnt_valid;
  logic [1:0]         gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               timeout;

  modport master (
    output req, done,
    input  gnt_valid, gnt_idx, gnt, timeout
  );

  modport slave (
    input  req, done,
    output gnt_valid, gnt_idx, gnt, timeout
  );
endinterface

// File: rtl/onehot_dec4.sv
// 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module onehot_dec4 (
  input  logic       en,
  input  logic [1:0] sel,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with per-grant hold limit and forced-release pulse.
//   state | meaning
//   IDLE  | no owner; searching from ptr for the next requester
//   GRANT | gnt_idx owns the resource; hcnt counts grant cycles
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input logic           clk,
  input logic           rst,
  rr_arbiter_4_if.slave bus
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_MAX - 1);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          found;
  logic [1:0]    pick;
  logic [1:0]    cand;
  logic          rel_user;
  logic          rel_limit;
  logic [3:0]    gnt_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      hcnt_q    <= '0;
      idx_q     <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hcnt_d    = hcnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    rel_user  = bus.done || !bus.req[idx_q];
    rel_limit = (hcnt_q == HCNT_LAST);
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = pick;
          valid_d = 1'b1;
          hcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        hcnt_d = hcnt_q + 1'b1;
        if (rel_user || rel_limit) begin
          // A voluntary release on the last allowed cycle is not a timeout.
          timeout_d = !rel_user;
          valid_d   = 1'b0;
          ptr_d     = inc_mod4(idx_q);
          hcnt_d    = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  onehot_dec4 u_dec (
    .en     (valid_q),
    .sel    (idx_q),
    .onehot (gnt_dec)
  );

  assign bus.gnt_valid = valid_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt       = gnt_dec;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed vector table, hold-limit sequences, and random traffic vs a reference model.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;

  int n_checks;
  int n_pass;

  rr_arbiter_4_if bus8 ();
  rr_arbiter_4_if bus1 ();

  assign bus8.req  = req;
  assign bus8.done = done;
  assign bus1.req  = req;
  assign bus1.done = done;

  rr_arbiter_4 #(.HOLD_MAX(8)) u8 (.clk(clk), .rst(rst), .bus(bus8));
  rr_arbiter_4 #(.HOLD_MAX(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: busy flag, owner, rotating start point and number of grant cycles already served.
  typedef struct {
    int busy;
    int owner;
    int ptr;
    int age;
    int to;
  } mstate_t;

  mstate_t m8, m1;

  function automatic mstate_t mstep(mstate_t s, logic [3:0] r, logic d, logic rs, int hmax);
    mstate_t n;
    int i;
    int voluntary;
    n    = s;
    n.to = 0;
    if (rs) begin
      n.busy = 0; n.owner = 0; n.ptr = 0; n.age = 0;
      return n;
    end
    if (s.busy == 0) begin
      for (int k = 3; k >= 0; k--) begin
        i = (s.ptr + k) % 4;
        if (r[i]) begin
          n.busy  = 1;
          n.owner = i;
          n.age   = 0;
        end
      end
    end else begin
      voluntary = (d || !r[s.owner]) ? 1 : 0;
      if (voluntary == 1 || s.age + 1 >= hmax) begin
        n.busy = 0;
        n.ptr  = (s.owner + 1) % 4;
        n.to   = (voluntary == 0) ? 1 : 0;
      end else begin
        n.age = s.age + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_model(input string tag, input logic v, input logic [1:0] idx,
                           input logic [3:0] g, input logic t, input mstate_t m);
    logic [3:0] eg;
    eg = (m.busy != 0) ? (4'b0001 << m.owner) : 4'b0000;
    chk({tag, ".gnt_valid"}, {31'd0, v}, m.busy);
    chk({tag, ".gnt_idx"},   {30'd0, idx}, m.owner);
    chk({tag, ".gnt"},       {28'd0, g}, {28'd0, eg});
    chk({tag, ".timeout"},   {31'd0, t}, m.to);
  endtask

  task automatic tick();
    @(posedge clk);
    m8 = mstep(m8, req, done, rst, 8);
    m1 = mstep(m1, req, done, rst, 1);
    #1;
    chk_model("u8", bus8.gnt_valid, bus8.gnt_idx, bus8.gnt, bus8.timeout, m8);
    chk_model("u1", bus1.gnt_valid, bus1.gnt_idx, bus1.gnt, bus1.timeout, m1);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       ev;
    logic [1:0] ei;
    logic [3:0] eg;
    logic       et;
  } vec_t;

  vec_t vt[26];

  initial begin
    int cnt;
    n_checks = 0;
    n_pass   = 0;
    m8 = '{0, 0, 0, 0, 0};
    m1 = '{0, 0, 0, 0, 0};
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;

    //          rst   req      done  ev    ei     eg       et
    vt[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    vt[1]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0};
    vt[2]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
    vt[3]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0};
    vt[4]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0};
    vt[5]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0};
    vt[6]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0};
    vt[7]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0};
    vt[8]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
    vt[9]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0};
    vt[10] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
    vt[11] = '{1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0};
    vt[12] = '{1'b0, 4'b0010, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0};
    vt[13] = '{1'b0, 4'b0011, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0};
    vt[14] = '{1'b0, 4'b0011, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0};
    vt[15] = '{1'b0, 4'b1010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0};
    vt[16] = '{1'b0, 4'b1010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0};
    vt[17] = '{1'b0, 4'b1010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0};
    vt[18] = '{1'b0, 4'b1000, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0};
    vt[19] = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000, 1'b0};
    vt[20] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0};
    vt[21] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0};
    vt[22] = '{1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100, 1'b0};
    vt[23] = '{1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
    vt[24] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0};
    vt[25] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};

    for (int v = 0; v < 26; v++) begin
      rst  = vt[v].rst;
      req  = vt[v].req;
      done = vt[v].done;
      tick();
      chk($sformatf("vec%0d.gnt_valid", v), {31'd0, bus8.gnt_valid}, {31'd0, vt[v].ev});
      chk($sformatf("vec%0d.gnt_idx", v),   {30'd0, bus8.gnt_idx},   {30'd0, vt[v].ei});
      chk($sformatf("vec%0d.gnt", v),       {28'd0, bus8.gnt},       {28'd0, vt[v].eg});
      chk($sformatf("vec%0d.timeout", v),   {31'd0, bus8.timeout},   {31'd0, vt[v].et});
    end

    // Held request with no done: exactly 8 grant cycles, timeout pulse, regrant after the bubble.
    rst  = 1'b0;
    req  = 4'b0100;
    done = 1'b0;
    tick();
    chk("hold.first_gnt", {28'd0, bus8.gnt}, 32'h4);
    chk("hold1.first_gnt", {28'd0, bus1.gnt}, 32'h4);
    cnt = 0;
    while (bus8.gnt == 4'b0100 && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("hold.grant_cycles", cnt, 8);
    chk("hold.timeout_pulse", {31'd0, bus8.timeout}, 32'd1);
    chk("hold.bubble_gnt", {28'd0, bus8.gnt}, 32'd0);
    tick();
    chk("hold.timeout_cleared", {31'd0, bus8.timeout}, 32'd0);
    chk("hold.regrant", {28'd0, bus8.gnt}, 32'h4);

    // done arriving on the last allowed cycle releases without timeout.
    for (int k = 0; k < 7; k++) tick();
    chk("limit.still_owner", {31'd0, bus8.gnt_valid}, 32'd1);
    done = 1'b1;
    tick();
    chk("limit.released", {31'd0, bus8.gnt_valid}, 32'd0);
    chk("limit.no_timeout", {31'd0, bus8.timeout}, 32'd0);
    done = 1'b0;
    tick();
    chk("limit.no_late_timeout", {31'd0, bus8.timeout}, 32'd0);
    chk("limit.regrant", {28'd0, bus8.gnt}, 32'h4);

    // Random traffic, both instances against the model every cycle.
    for (int c = 0; c < 600; c++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
